// File: rtl/ex_wb_stage.sv
// ex_wb_stage: two-entry skid FIFO between the ALU and writeback.
// Architectural Z/N flags are updated when a beat is accepted, not when it retires.
// Also counts retired beats, saturating at 16'hFFFF.
module ex_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_we,
  input  logic              in_set,
  input  logic              in_z,
  input  logic              in_n,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_we,
  output logic              flag_z,
  output logic              flag_n,
  output logic [15:0]       retired
);

  logic [1:0]  count_reg, count_next;
  logic        wr_ptr_reg, wr_ptr_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic        live_reg;
  logic        flag_z_reg, flag_z_next;
  logic        flag_n_reg, flag_n_next;
  logic [15:0] retired_reg, retired_next;
  logic        push, pop;

  // Entry storage is intentionally unreset; out_valid qualifies its contents.
  logic [DATA_W-1:0] result_mem [2];
  logic [REG_W-1:0]  rd_mem     [2];
  logic              we_mem     [2];

  // Handshake decode uses registered state only, so out_ready never reaches in_ready.
  // live_reg holds in_ready low until the first edge after reset is released.
  assign in_ready  = live_reg && (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign out_result = result_mem[rd_ptr_reg];
  assign out_rd     = rd_mem[rd_ptr_reg];
  assign out_we     = we_mem[rd_ptr_reg];
  assign flag_z     = flag_z_reg;
  assign flag_n     = flag_n_reg;
  assign retired    = retired_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      localparam logic IDX = 1'(gi);
      // Capture the incoming beat into this slot when the write pointer selects it.
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == IDX)) begin
          result_mem[gi] <= in_result;
          rd_mem[gi]     <= in_rd;
          we_mem[gi]     <= in_we;
        end
      end
    end
  endgenerate

  // Next-state for occupancy, pointers, flags and retire counter; flush overrides everything.
  always_comb begin
    count_next   = count_reg;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    flag_z_next  = flag_z_reg;
    flag_n_next  = flag_n_reg;
    retired_next = retired_reg;
    if (flush) begin
      count_next  = 2'd0;
      wr_ptr_next = 1'b0;
      rd_ptr_next = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_next = ~wr_ptr_reg;
        if (in_set) begin
          flag_z_next = in_z;
          flag_n_next = in_n;
        end
      end
      if (pop) begin
        rd_ptr_next = ~rd_ptr_reg;
        if (retired_reg != 16'hFFFF) retired_next = retired_reg + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= 2'd0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      live_reg    <= 1'b0;
      flag_z_reg  <= 1'b0;
      flag_n_reg  <= 1'b0;
      retired_reg <= 16'd0;
    end else begin
      count_reg   <= count_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      live_reg    <= 1'b1;
      flag_z_reg  <= flag_z_next;
      flag_n_reg  <= flag_n_next;
      retired_reg <= retired_next;
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage: directed vectors with hand-computed expectations for ex_wb_stage.
module tb_ex_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_rd;
  logic        in_we, in_set, in_z, in_n, flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_we, flag_z, flag_n;
  logic [15:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  ex_wb_stage #(.DATA_W(32), .REG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rd(in_rd), .in_we(in_we),
    .in_set(in_set), .in_z(in_z), .in_n(in_n),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
    .flag_z(flag_z), .flag_n(flag_n), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // advance one clock; outputs settle 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] r, input logic [3:0] rd,
                      input logic set, input logic z, input logic n);
    in_valid = 1'b1; in_result = r; in_rd = rd; in_we = 1'b1;
    in_set = set; in_z = z; in_n = n;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_rd = '0; in_we = 1'b0;
    in_set = 1'b0; in_z = 1'b0; in_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_flags", {30'd0, flag_z, flag_n}, 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("ready_low_before_edge", 32'(in_ready), 32'd0);
    step();
    check("ready_after_edge", 32'(in_ready), 32'd1);

    // single beat, latency one cycle
    beat(32'h5, 4'd3, 1'b1, 1'b0, 1'b0); out_ready = 1'b1;
    step(); in_valid = 1'b0;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_result", out_result, 32'h5);
    check("lat_out_rd", 32'(out_rd), 32'd3);
    check("lat_out_we", 32'(out_we), 32'd1);
    step();
    check("lat_drain_valid", 32'(out_valid), 32'd0);
    check("lat_retired", 32'(retired), 32'd1);

    // backpressure: A,B fill the stage, C waits upstream
    out_ready = 1'b0;
    beat(32'hA, 4'd1, 1'b0, 1'b0, 1'b0); step();
    check("bp_ready_1", 32'(in_ready), 32'd1);
    beat(32'hB, 4'd2, 1'b0, 1'b0, 1'b0); step();
    check("bp_ready_full", 32'(in_ready), 32'd0);
    beat(32'hC, 4'd4, 1'b0, 1'b0, 1'b0); step();
    check("bp_ready_still_full", 32'(in_ready), 32'd0);
    check("bp_head_held", out_result, 32'hA);
    out_ready = 1'b1;
    step();
    check("bp_second", out_result, 32'hB);
    check("bp_ready_reopen", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    check("bp_third", out_result, 32'hC);
    check("bp_third_rd", 32'(out_rd), 32'd4);
    step();
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_retired", 32'(retired), 32'd4);

    // flags update at acceptance
    beat(32'h0, 4'd5, 1'b1, 1'b1, 1'b0); step();
    check("flag_z_set", 32'(flag_z), 32'd1);
    beat(32'h7, 4'd5, 1'b0, 1'b0, 1'b0); step();
    check("flag_z_hold", 32'(flag_z), 32'd1);
    beat(32'h8000_0000, 4'd5, 1'b1, 1'b0, 1'b1); step(); in_valid = 1'b0;
    check("flag_n_set", 32'(flag_n), 32'd1);
    check("flag_z_clear", 32'(flag_z), 32'd0);
    step();
    check("flag_retired", 32'(retired), 32'd7);

    // flush while full with concurrent push and pop
    out_ready = 1'b0;
    beat(32'h11, 4'd6, 1'b0, 1'b0, 1'b0); step();
    beat(32'h22, 4'd7, 1'b0, 1'b0, 1'b0); step();
    check("fl_full", 32'(in_ready), 32'd0);
    beat(32'h33, 4'd8, 1'b1, 1'b1, 1'b0); out_ready = 1'b1; flush = 1'b1;
    step(); flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    check("fl_flag_z", 32'(flag_z), 32'd0);
    check("fl_retired", 32'(retired), 32'd7);

    // streaming, one beat per cycle
    for (int i = 0; i < 8; i++) begin
      beat(32'h100 + 32'(i), 4'(i), 1'b0, 1'b0, 1'b0);
      step();
      check($sformatf("st_result_%0d", i), out_result, 32'h100 + 32'(i));
      check($sformatf("st_ready_%0d", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0; step();
    check("st_empty", 32'(out_valid), 32'd0);
    check("st_retired", 32'(retired), 32'd15);

    // asynchronous reset with a beat held
    out_ready = 1'b0;
    beat(32'h99, 4'd9, 1'b1, 1'b1, 1'b1); step(); in_valid = 1'b0;
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0; #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd0);
    check("ar_flags", {30'd0, flag_z, flag_n}, 32'd0);
    check("ar_retired", 32'(retired), 32'd0);
    @(negedge clk); rst_n = 1'b1; step();
    check("ar_recover_ready", 32'(in_ready), 32'd1);
    check("ar_recover_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
EX_WB_STAGE -- requirements
Module: ex_wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, ALU result width.
REQ-002 Parameter REG_W, default 4, destination register index width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream ALU beat present.
REQ-006 in_ready  output  1  stage can accept a beat this cycle.
REQ-007 in_result  input  DATA_W  ALU result.
REQ-008 in_rd  input  REG_W  destination register index.
REQ-009 in_we  input  1  beat writes the register file.
REQ-010 in_set  input  1  beat updates the architectural flags.
REQ-011 in_z, in_n  input  1 each  ALU zero/negative flags for this beat.
REQ-012 flush  input  1  synchronous discard of all held and incoming beats.
REQ-013 out_valid  output  1  head beat presented to writeback.
REQ-014 out_ready  input  1  writeback consumes the head beat.
REQ-015 out_result  output  DATA_W; out_rd  output  REG_W; out_we  output  1  fields of the head beat.
REQ-016 flag_z, flag_n  output  1 each  architectural Z and N flags.
REQ-017 retired  output  16  count of beats consumed at the output.

Function
REQ-018 The stage SHALL be a 2-entry FIFO: storage of {result, rd, we}, read pointer, write pointer, and a 0..2 occupancy count.
REQ-019 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-020 in_ready SHALL be 1 iff count < 2, decoded from registered count only (no combinational path from out_ready).
REQ-021 out_valid SHALL be 1 iff count != 0; out_result/out_rd/out_we SHALL show the entry at the read pointer, and SHALL be held stable while out_valid && !out_ready.
REQ-022 Latency: a beat pushed into an empty stage SHALL appear with out_valid=1 on the next cycle.
REQ-023 Push and pop in the same cycle with count=1 SHALL leave count=1 and present the new beat next cycle; sustained throughput SHALL be one beat per cycle.
REQ-024 At count=2, in_ready=0 and no push SHALL occur even if a pop occurs that cycle.
REQ-025 Pointers SHALL be 1 bit and wrap 1 -> 0.
REQ-026 On push with in_set=1, flag_z/flag_n SHALL take in_z/in_n at that edge; with in_set=0 flags SHALL hold.
REQ-027 Flags SHALL be updated at acceptance, not at retirement, so the next upstream instruction observes them one cycle after its producer is accepted.
REQ-028 flush=1 SHALL at the next edge set count=0 and both pointers=0, discard any concurrent push (no flag update) and concurrent pop (no retired increment); flags and retired SHALL otherwise hold.
REQ-029 retired SHALL increment by 1 per pop and saturate at 16'hFFFF.
REQ-030 Storage contents need not be reset; outputs derived from them SHALL be ignored while out_valid=0.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately, without clock, force count=0, pointers=0, out_valid=0, in_ready=0 while reset is held, flag_z=0, flag_n=0, retired=0.
REQ-032 in_ready SHALL rise to 1 on the first rising edge after rst_n deasserts; reset mid-transfer SHALL drop all held beats.

Verification
REQ-033 Empty, push result=32'h0000_0005 rd=3 we=1 set=1 z=0 n=0, out_ready=1 -> next cycle out_valid=1 out_result=5 out_rd=3; cycle after, out_valid=0, retired=1.
REQ-034 out_ready=0, push 3 back-to-back beats A,B,C -> A,B accepted, in_ready=0 on third cycle, C held upstream; raise out_ready -> A,B,C emerge in order, no loss or duplicate.
REQ-035 Push result=0 set=1 z=1 -> flag_z=1 next cycle; then push set=0 z=0 -> flag_z stays 1; push set=1 n=1 z=0 -> flag_n=1 flag_z=0.
REQ-036 count=2, assert flush with in_valid=1 set=1 z=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, flag_z unchanged, retired unchanged.
REQ-037 Stream of 8 beats with in_valid=1 and out_ready=1 every cycle -> one beat retired per cycle, count never exceeds 1, retired=8.
REQ-038 Hold count=1, pulse rst_n=0 asynchronously mid-cycle -> out_valid=0, flags=0, retired=0 before the next clock edge.
